// File: rtl/rd53_pkg.sv
// Shared types and sizes for the rd53 serial vector loader.
// RD53_VEC_PARITY_EN adds the PAR state, which checks a trailing even-parity bit.
package rd53_pkg;

   localparam int VEC_W = 5;
   localparam int CNT_W = 8;
   localparam int IDX_W = 3;

`ifdef RD53_VEC_PARITY_EN
   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      PAR     = 2'd1,
      HOLD    = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      HOLD    = 2'd2
   } state_t;
`endif

   // Even parity: the word bits and the parity bit together XOR to zero.
   function automatic logic even_par_ok(input logic [VEC_W-1:0] w, input logic p);
      return ~((^w) ^ p);
   endfunction

endpackage

// File: rtl/rd53_shift5.sv
// Five-bit collecting register with its bit-index counter.
// word shows the register contents with this cycle's incoming bit already merged in.
module rd53_shift5
   import rd53_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             bit_in,
   output logic [VEC_W-1:0] word,
   output logic             last
);

   logic [IDX_W-1:0] idx;
   logic [VEC_W-1:0] sreg;

   always_comb begin
      word = sreg;
      if (shift_en) begin
         for (int i = 0; i < VEC_W; i++) begin
            if (idx == IDX_W'(i)) word[i] = bit_in;
         end
      end
   end

   assign last = (idx == IDX_W'(VEC_W - 1));

   // The index wraps after the last bit so the next word always starts at bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx  <= '0;
         sreg <= '0;
      end else if (clr) begin
         idx  <= '0;
      end else if (shift_en) begin
         sreg <= word;
         idx  <= last ? '0 : idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/rd53_vec_loader.sv
// Serial-to-parallel loader feeding x0..x4 of the rd53 function stage.
// Define RD53_VEC_PARITY_EN to require a sixth, even-parity bit per word.
module rd53_vec_loader
   import rd53_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             sin_valid,
   input  logic             sin_data,
   output logic             sin_ready,
   input  logic             sin_clr,
   output logic             x0,
   output logic             x1,
   output logic             x2,
   output logic             x3,
   output logic             x4,
   output logic             vec_valid,
   input  logic             vec_ready,
   output logic [CNT_W-1:0] vec_cnt,
   output logic             par_err
);

   state_t           state, nxt;
   logic             shift_en, clr_sh, load_x, cnt_inc, last;
   logic [VEC_W-1:0] word, xr;
`ifdef RD53_VEC_PARITY_EN
   logic             par_fail;
`endif

   rd53_shift5 u_shift (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_sh),
      .shift_en (shift_en),
      .bit_in   (sin_data),
      .word     (word),
      .last     (last)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= COLLECT;
      else     state <= nxt;
   end

   always_comb begin
      nxt       = state;
      sin_ready = 1'b1;
      shift_en  = 1'b0;
      clr_sh    = 1'b0;
      load_x    = 1'b0;
      cnt_inc   = 1'b0;
`ifdef RD53_VEC_PARITY_EN
      par_fail  = 1'b0;
`endif
      case (state)
         COLLECT: begin
            if (sin_clr) begin
               clr_sh = 1'b1;
            end else if (sin_valid) begin
               shift_en = 1'b1;
               if (last) begin
`ifdef RD53_VEC_PARITY_EN
                  nxt = PAR;
`else
                  load_x = 1'b1;
                  nxt    = HOLD;
`endif
               end
            end
         end
`ifdef RD53_VEC_PARITY_EN
         // The register is full and frozen here; word equals the stored five bits.
         PAR: begin
            if (sin_clr) begin
               clr_sh = 1'b1;
               nxt    = COLLECT;
            end else if (sin_valid) begin
               if (even_par_ok(word, sin_data)) begin
                  load_x = 1'b1;
                  nxt    = HOLD;
               end else begin
                  par_fail = 1'b1;
                  clr_sh   = 1'b1;
                  nxt      = COLLECT;
               end
            end
         end
`endif
         HOLD: begin
            // A bit taken on the handshake cycle is bit 0 of the next word; sin_clr is ignored.
            sin_ready = vec_ready;
            if (vec_ready) begin
               cnt_inc  = 1'b1;
               shift_en = sin_valid;
               nxt      = COLLECT;
            end
         end
         default: nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xr      <= '0;
         vec_cnt <= '0;
      end else begin
         if (load_x)  xr      <= word;
         if (cnt_inc) vec_cnt <= vec_cnt + CNT_W'(1);
      end
   end

`ifdef RD53_VEC_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) par_err <= 1'b0;
      else     par_err <= par_fail;
   end
`else
   assign par_err = 1'b0;
`endif

   assign vec_valid = (state == HOLD);
   assign x0 = xr[0];
   assign x1 = xr[1];
   assign x2 = xr[2];
   assign x3 = xr[3];
   assign x4 = xr[4];

endmodule

// File: doc/rd53_vec_loader.md
RD53_VEC_LOADER -- requirements
Module: rd53_vec_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port sin_valid, input, 1 bit: serial bit offered.
REQ-004 SHALL have port sin_data, input, 1 bit: serial data bit.
REQ-005 SHALL have port sin_ready, output, 1 bit: the loader accepts the serial bit this cycle.
REQ-006 SHALL have port sin_clr, input, 1 bit: abort the partial word.
REQ-007 SHALL have ports x0..x4, output, 1 bit each: registered vector presented to the downstream rd53 function stage.
REQ-008 SHALL have port vec_valid, output, 1 bit: x0..x4 hold a complete word.
REQ-009 SHALL have port vec_ready, input, 1 bit: downstream consumes the word.
REQ-010 SHALL have port vec_cnt, output, 8 bits: count of delivered words.
REQ-011 SHALL have port par_err, output, 1 bit: one-cycle parity-fail pulse.

Function
REQ-012 SHALL accept a bit on any cycle where sin_valid && sin_ready.
REQ-013 SHALL place accepted bits first-to-last into x0, x1, x2, x3, x4.
REQ-014 SHALL use states COLLECT, PAR and HOLD; COLLECT SHALL track bit index 0..4.
REQ-015 In COLLECT: sin_ready=1, vec_valid=0, and x0..x4 SHALL stay unchanged until the word completes.
REQ-016 On acceptance of the 5th bit (PAR disabled), SHALL load x0..x4 and enter HOLD, with vec_valid=1 on the next cycle.
REQ-017 In HOLD: x0..x4 SHALL be stable and vec_valid=1 until vec_valid && vec_ready.
REQ-018 In HOLD: sin_ready SHALL equal vec_ready, so a bit accepted on the handshake cycle becomes bit 0 of the next word.
REQ-019 On handshake, SHALL go to COLLECT with index 0, or index 1 if a bit was accepted that cycle.
REQ-020 vec_cnt SHALL increment by 1 per handshake and wrap from 255 to 0.
REQ-021 sin_clr in COLLECT or PAR SHALL discard the partial word, return to index 0 and drop any bit offered that cycle.
REQ-022 sin_clr in HOLD SHALL be ignored, so a complete word is never lost.
REQ-023 Throughput SHALL be one word per 5 cycles (6 with parity) under continuous sin_valid and vec_ready.

Reset
REQ-024 On rst: state=COLLECT, index=0, x0..x4=0, vec_valid=0, sin_ready=1, vec_cnt=0, par_err=0.
REQ-025 rst SHALL override all inputs, including an in-flight handshake; a word held in HOLD is dropped and not counted.

Configuration
REQ-026 With macro RD53_VEC_PARITY_EN defined:
- after the 5th bit the block SHALL enter PAR and accept a 6th bit as even parity over all 6 bits;
- on match it SHALL enter HOLD;
- on mismatch it SHALL discard the word, pulse par_err for one cycle, return to COLLECT index 0, and SHALL NOT increment vec_cnt.
REQ-027 Without RD53_VEC_PARITY_EN, the PAR state SHALL NOT exist and par_err SHALL be tied to 0.

Structure
REQ-028 Package rd53_pkg SHALL hold the state enum, VEC_W=5 and CNT_W=8.
REQ-029 The shift register and bit-index counter SHALL be the sub-module rd53_shift5; the FSM, handshake logic and counters stay in the top module.

Verification
REQ-030 Serial bits 1,1,0,1,1 with vec_ready=1 -> x0..x4=1,1,0,1,1, vec_valid for exactly 1 cycle, vec_cnt=1.
REQ-031 Word complete, vec_ready=0 for 10 cycles -> x0..x4 stable, sin_ready=0, vec_valid=1 throughout; then vec_ready=1 -> handshake, vec_cnt increments.
REQ-032 3 bits, then sin_clr together with sin_valid, then bits 0,0,1,0,1 -> x0..x4=0,0,1,0,1 (the partial word and the clr-cycle bit are absent).
REQ-033 256 words streamed continuously -> vec_cnt wraps to 0 and one word completes every 5 cycles.
REQ-034 With RD53_VEC_PARITY_EN: bits 1,0,0,0,0 plus parity 0 -> par_err pulse, no vec_valid, vec_cnt unchanged; with parity 1 -> word delivered.
REQ-035 rst asserted while in HOLD -> next cycle vec_valid=0, x0..x4=0, vec_cnt=0.
